// File: rtl/w5300_pkg.sv
// Shared types and constants for the W5300-style asynchronous bus responder.
// The bus word index is addr[9:1], so at most 512 words are addressable.
package w5300_pkg;

    localparam int W5300_ADDR_W = 10;
    localparam int W5300_DATA_W = 16;
    localparam int W5300_IDX_W  = W5300_ADDR_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_HOLD,
        ERR
    } w5300_state_e;

    function automatic logic idx_in_range(input logic [W5300_IDX_W-1:0] idx, input int depth);
        return (int'(idx) < depth);
    endfunction

endpackage

// File: rtl/w5300_sync2.sv
// Parameterised-width two-flop synchronizer with a per-instance reset value.
module w5300_sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/w5300_bus_responder.sv
// Responds to an asynchronous chip-select/read/write strobe bus with a small word memory,
// bus read/write counters and a sticky flag for simultaneous read+write strobes.
module w5300_bus_responder
    import w5300_pkg::*;
#(
    parameter int CLK_FREQ = 100,
    parameter int RD_LAT   = 3,
    parameter int DEPTH    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cs_n,
    input  logic                       rd_n,
    input  logic                       we_n,
    input  logic [W5300_ADDR_W-1:0]    addr,
    inout  wire  [W5300_DATA_W-1:0]    data,
    input  logic [$clog2(DEPTH)-1:0]   bd_addr,
    output logic [W5300_DATA_W-1:0]    bd_rdata,
    output logic [15:0]                rd_count,
    output logic [15:0]                wr_count,
    output logic                       proto_err
);

    localparam int IDX_W = $clog2(DEPTH);

    if (RD_LAT < 1 || RD_LAT > 15 || CLK_FREQ < 1 || DEPTH > 512 || (1 << IDX_W) != DEPTH) begin : g_bad_param
        $error("w5300_bus_responder: illegal parameter combination");
    end

    logic [2:0]              s_strb;
    logic                    s_cs_n, s_rd_n, s_we_n;
    logic [W5300_ADDR_W-1:0] s_addr;
    logic [W5300_DATA_W-1:0] s_data;
    logic                    unused_addr_lsb;

    w5300_sync2 #(.W(3), .RST_VAL(3'b111)) u_sync_strb (
        .clk(clk), .rst(rst), .d({cs_n, rd_n, we_n}), .q(s_strb)
    );
    w5300_sync2 #(.W(W5300_ADDR_W), .RST_VAL('0)) u_sync_addr (
        .clk(clk), .rst(rst), .d(addr), .q(s_addr)
    );
    w5300_sync2 #(.W(W5300_DATA_W), .RST_VAL('0)) u_sync_data (
        .clk(clk), .rst(rst), .d(data), .q(s_data)
    );

    assign {s_cs_n, s_rd_n, s_we_n} = s_strb;
    assign unused_addr_lsb = s_addr[0];

    w5300_state_e            state_q, state_d;
    logic [3:0]              lat_q, lat_d;
    logic [W5300_IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [W5300_IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [W5300_DATA_W-1:0] wr_data_q, wr_data_d;
    logic [W5300_DATA_W-1:0] dout_q, dout_d;
    logic [15:0]             rd_count_q, rd_count_d;
    logic [15:0]             wr_count_q, wr_count_d;
    logic                    proto_err_q, proto_err_d;
    logic                    data_oe;
    logic                    mem_we;
    logic [W5300_DATA_W-1:0] mem_q [DEPTH];

    logic both_low, rd_req, wr_req;
    assign both_low = !s_cs_n && !s_rd_n && !s_we_n;
    assign rd_req   = !s_cs_n && !s_rd_n &&  s_we_n;
    assign wr_req   = !s_cs_n && !s_we_n &&  s_rd_n;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        rd_idx_d    = rd_idx_q;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        dout_d      = dout_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        proto_err_d = proto_err_q;
        data_oe     = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (both_low) begin
                    state_d     = ERR;
                    proto_err_d = 1'b1;
                end else if (rd_req) begin
                    state_d  = RD_WAIT;
                    rd_idx_d = s_addr[W5300_ADDR_W-1:1];
                    lat_d    = 4'(RD_LAT);
                end else if (wr_req) begin
                    state_d   = WR_HOLD;
                    wr_idx_d  = s_addr[W5300_ADDR_W-1:1];
                    wr_data_d = s_data;
                end
            end
            RD_WAIT: begin
                // Drive on the edge where the decremented count reaches 1, so the
                // entry cycle counts as the first of the RD_LAT latency cycles.
                lat_d = lat_q - 4'd1;
                if (both_low) begin
                    state_d     = ERR;
                    proto_err_d = 1'b1;
                end else if (s_rd_n || s_cs_n) begin
                    state_d = IDLE;
                end else if (lat_q <= 4'd2) begin
                    state_d = RD_DRIVE;
                    dout_d  = idx_in_range(rd_idx_q, DEPTH) ? mem_q[rd_idx_q[IDX_W-1:0]] : '0;
                end
            end
            RD_DRIVE: begin
                if (s_rd_n || s_cs_n) begin
                    state_d    = IDLE;
                    rd_count_d = rd_count_q + 16'd1;
                end else begin
                    data_oe = 1'b1;
                end
            end
            WR_HOLD: begin
                if (both_low) begin
                    state_d     = ERR;
                    proto_err_d = 1'b1;
                end else if (s_we_n || s_cs_n) begin
                    state_d    = IDLE;
                    wr_count_d = wr_count_q + 16'd1;
                    mem_we     = idx_in_range(wr_idx_q, DEPTH);
                end else begin
                    wr_idx_d  = s_addr[W5300_ADDR_W-1:1];
                    wr_data_d = s_data;
                end
            end
            ERR: begin
                if (s_cs_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            dout_q      <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            dout_q      <= dout_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[wr_idx_q[IDX_W-1:0]] <= wr_data_q;
        end
    end

    assign data      = data_oe ? dout_q : 'z;
    assign bd_rdata  = mem_q[bd_addr];
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_w5300_bus_responder.sv
// Scoreboard bench for w5300_bus_responder: bus reads/writes, range limits, protocol error,
// short strobes, reset during a read and 16-bit write-counter wrap.
module tb_w5300_bus_responder;

    localparam int DEPTH = 64;
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, rd_n, we_n;
    logic [9:0]  addr;
    wire  [15:0] data;
    logic [5:0]  bd_addr;
    logic [15:0] bd_rdata, rd_count, wr_count;
    logic        proto_err;

    logic        tb_drive;
    logic [15:0] tb_data;

    assign data = tb_drive ? tb_data : 16'hzzzz;

    // Undriven bus floats high so a released bus reads as BUS_IDLE.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (data[g]);
    end

    w5300_bus_responder #(.CLK_FREQ(100), .RD_LAT(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .we_n(we_n), .addr(addr),
        .data(data), .bd_addr(bd_addr), .bd_rdata(bd_rdata), .rd_count(rd_count),
        .wr_count(wr_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_mem [DEPTH];
    logic [15:0] model_rd, model_wr;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rd = '0;
        model_wr = '0;
        exp_q.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; we_n = 1'b1;
        addr = '0; tb_drive = 1'b0; tb_data = '0; bd_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; tb_data = d; tb_drive = 1'b1; cs_n = 1'b0; we_n = 1'b0;
        repeat (4) @(negedge clk);
        we_n = 1'b1; cs_n = 1'b1;
        repeat (4) @(negedge clk);
        tb_drive = 1'b0;
        if (int'(a[9:1]) < DEPTH) model_mem[a[9:1]] = d;
        model_wr = model_wr + 16'd1;
    endtask

    task automatic bus_read(input logic [9:0] a, input string name);
        logic [15:0] e;
        int          n;
        bit          seen;
        exp_q.push_back((int'(a[9:1]) < DEPTH) ? model_mem[a[9:1]] : 16'h0000);
        @(negedge clk);
        addr = a; tb_drive = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
        seen = 1'b0; n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (data !== BUS_IDLE) begin
                seen = 1'b1; n = i;
                break;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: bus never driven within 10 cycles, expected 0x%04h", name, e);
        end else begin
            if (data !== e) begin
                errors++;
                $display("FAIL %s_data: got 0x%04h expected 0x%04h", name, data, e);
            end
            checks++;
            if (n > 5) begin
                errors++;
                $display("FAIL %s_latency: got %0d cycles expected <= 5", name, n);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL %s_hold: got 0x%04h expected 0x%04h", name, data, e);
            end
        end
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (data !== BUS_IDLE) begin
            errors++;
            $display("FAIL %s_release: got 0x%04h expected released bus", name, data);
        end
        repeat (2) @(negedge clk);
        model_rd = model_rd + 16'd1;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        checks++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got rd=%0d wr=%0d perr=%0b expected 0 0 0", rd_count, wr_count, proto_err);
        end
        checks++;
        if (data !== BUS_IDLE) begin
            errors++;
            $display("FAIL reset_bus: got 0x%04h expected released bus", data);
        end
        for (int i = 0; i < DEPTH; i += 21) begin
            bd_addr = 6'(i);
            #1;
            checks++;
            if (bd_rdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_mem[%0d]: got 0x%04h expected 0x0000", i, bd_rdata);
            end
        end
    endtask

    task automatic test_write_read();
        bus_write(10'h004, 16'hA5A5);
        bus_read(10'h004, "wr_rd");
        checks++;
        if (wr_count !== 16'd1 || rd_count !== 16'd1) begin
            errors++;
            $display("FAIL wr_rd_counts: got rd=%0d wr=%0d expected 1 1", rd_count, wr_count);
        end
        bd_addr = 6'd2;
        #1;
        checks++;
        if (bd_rdata !== 16'hA5A5) begin
            errors++;
            $display("FAIL wr_rd_bd: got 0x%04h expected 0xa5a5", bd_rdata);
        end
    endtask

    task automatic test_random();
        logic [9:0] addrs [6];
        for (int i = 0; i < 6; i++) begin
            addrs[i] = {3'b000, 6'($urandom_range(3, DEPTH - 1)), 1'b0};
            bus_write(addrs[i], 16'($urandom_range(0, 16'hFFFE)));
        end
        for (int i = 5; i >= 0; i--) bus_read(addrs[i], "rand");
        checks++;
        if (wr_count !== model_wr || rd_count !== model_rd) begin
            errors++;
            $display("FAIL rand_counts: got rd=%0d wr=%0d expected %0d %0d", rd_count, wr_count, model_rd, model_wr);
        end
    endtask

    task automatic test_out_of_range();
        bus_read(10'h3FE, "oor_read");
        bus_write(10'h3FE, 16'h1234);
        checks++;
        if (wr_count !== model_wr) begin
            errors++;
            $display("FAIL oor_wr_count: got %0d expected %0d", wr_count, model_wr);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bd_addr = 6'(i);
            #1;
            checks++;
            if (bd_rdata !== model_mem[i]) begin
                errors++;
                $display("FAIL oor_mem[%0d]: got 0x%04h expected 0x%04h", i, bd_rdata, model_mem[i]);
            end
        end
    endtask

    task automatic test_short_pulse();
        bit driven = 1'b0;
        @(negedge clk);
        addr = 10'h004; tb_drive = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rd_n = 1'b1; cs_n = 1'b1;
            end
            if (data !== BUS_IDLE) driven = 1'b1;
        end
        checks++;
        if (driven) begin
            errors++;
            $display("FAIL short_pulse_drive: got driven=1 expected 0");
        end
        checks++;
        if (rd_count !== model_rd) begin
            errors++;
            $display("FAIL short_pulse_count: got %0d expected %0d", rd_count, model_rd);
        end
    endtask

    task automatic test_proto_err();
        bit driven = 1'b0;
        @(negedge clk);
        addr = 10'h008; tb_drive = 1'b0; cs_n = 1'b0; rd_n = 1'b0; we_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (data !== BUS_IDLE) driven = 1'b1;
        end
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_set: got %0b expected 1", proto_err);
        end
        checks++;
        if (driven) begin
            errors++;
            $display("FAIL perr_bus: got driven=1 expected released bus");
        end
        cs_n = 1'b1; rd_n = 1'b1; we_n = 1'b1;
        repeat (4) @(negedge clk);
        bd_addr = 6'd4;
        #1;
        checks++;
        if (bd_rdata !== model_mem[4] || wr_count !== model_wr) begin
            errors++;
            $display("FAIL perr_nowrite: got mem4=0x%04h wr=%0d expected 0x%04h %0d", bd_rdata, wr_count, model_mem[4], model_wr);
        end
        bus_write(10'h00C, 16'h0F0F);
        bus_read(10'h00C, "perr_after");
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: got %0b expected 1", proto_err);
        end
    endtask

    task automatic test_reset_mid_read();
        bit seen = 1'b0;
        @(negedge clk);
        addr = 10'h004; tb_drive = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data !== BUS_IDLE) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || data !== 16'hA5A5) begin
            errors++;
            $display("FAIL rst_rd_drive: got 0x%04h expected 0xa5a5 before reset", data);
        end
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1;
        bd_addr = 6'd2;
        @(negedge clk);
        checks++;
        if (data !== BUS_IDLE) begin
            errors++;
            $display("FAIL rst_rd_bus: got 0x%04h expected released bus", data);
        end
        checks++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0 || proto_err !== 1'b0 || bd_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL rst_rd_state: got rd=%0d wr=%0d perr=%0b mem2=0x%04h expected 0 0 0 0x0000",
                     rd_count, wr_count, proto_err, bd_rdata);
        end
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        addr = 10'h3FE; tb_data = 16'h5A5A; tb_drive = 1'b1; cs_n = 1'b0; we_n = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk); we_n = 1'b0;
            @(negedge clk); we_n = 1'b1;
            model_wr = model_wr + 16'd1;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_count !== model_wr) begin
            errors++;
            $display("FAIL wrap_ffff: got 0x%04h expected 0x%04h", wr_count, model_wr);
        end
        @(negedge clk); we_n = 1'b0;
        @(negedge clk); we_n = 1'b1;
        model_wr = model_wr + 16'd1;
        repeat (4) @(negedge clk);
        cs_n = 1'b1; tb_drive = 1'b0;
        checks++;
        if (wr_count !== model_wr) begin
            errors++;
            $display("FAIL wrap_zero: got 0x%04h expected 0x%04h", wr_count, model_wr);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_perr: got %0b expected 0", proto_err);
        end
        bd_addr = 6'd63;
        #1;
        checks++;
        if (bd_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_mem63: got 0x%04h expected 0x0000", bd_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_random();
        test_out_of_range();
        test_short_pulse();
        test_proto_err();
        test_reset_mid_read();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
